// File: rtl/hamming_emisor_serie_pkg.sv
// Shared definitions for the serial Hamming transmitter: codeword bit
// positions and FSM state encodings.
package hamming_pkg;

    localparam int P1   = 0;
    localparam int P2   = 1;
    localparam int D1   = 2;
    localparam int P4   = 3;
    localparam int D2   = 4;
    localparam int D3   = 5;
    localparam int D4   = 6;
    localparam int PALL = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/hamming_emisor_serie_if.sv
// Word-in / serial-out bundle of the Hamming transmitter.
interface hamming_emisor_serie_if #(
    parameter int NUM_NIBBLES = 2
);
    logic [4*NUM_NIBBLES-1:0] d_in;
    logic                     d_valid;
    logic                     d_ready;
    logic                     tx;
    logic                     busy;
    logic                     done;

    modport master (output d_in, d_valid, input d_ready, tx, busy, done);
    modport slave  (input d_in, d_valid, output d_ready, tx, busy, done);
endinterface

// File: rtl/hamming_emisor_serie_cod74.sv
// Combinational Hamming(7,4) encoder; bit 7 carries the overall parity so the
// same block serves the SECDED(8,4) variant.
module hamming_cod74
    import hamming_pkg::*;
(
    input  logic [3:0] i_data,
    output logic [7:0] o_cw
);
    logic [6:0] w_cw_low;

    always_comb begin
        w_cw_low     = '0;
        w_cw_low[P1] = i_data[0] ^ i_data[1] ^ i_data[3];
        w_cw_low[P2] = i_data[0] ^ i_data[2] ^ i_data[3];
        w_cw_low[D1] = i_data[0];
        w_cw_low[P4] = i_data[1] ^ i_data[2] ^ i_data[3];
        w_cw_low[D2] = i_data[1];
        w_cw_low[D3] = i_data[2];
        w_cw_low[D4] = i_data[3];
    end

    assign o_cw = {^w_cw_low, w_cw_low};
endmodule

// File: rtl/hamming_emisor_serie.sv
// Serial transmitter: captures a word of nibbles and sends each nibble as a
// start bit, its Hamming codeword LSB first, and a stop bit.
module hamming_emisor_serie
    import hamming_pkg::*;
#(
    parameter int NUM_NIBBLES = 2,
    parameter int EXTENDED    = 0,
    parameter int CLK_DIV     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hamming_emisor_serie_if.slave  bus
);
    localparam int              W        = 7 + EXTENDED;
    localparam int              NW       = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
    localparam int              NP       = 2 ** NW;
    localparam logic [NW-1:0]   LAST_NIB = NW'(NUM_NIBBLES - 1);
    localparam logic [15:0]     LAST_DIV = 16'(CLK_DIV - 1);
    localparam logic [2:0]      LAST_BIT = 3'(W - 1);

    state_t                   r_state, w_state_next;
    logic [4*NUM_NIBBLES-1:0] r_word, w_word_next;
    logic [NW-1:0]            r_nib, w_nib_next;
    logic [2:0]               r_bit, w_bit_next;
    logic [15:0]              r_div, w_div_next;
    logic                     r_tx, w_tx_next;
    logic                     w_period_end;
    logic [3:0]               w_nib_arr [NP];
    logic [7:0]               w_cw;

    assign w_period_end = (r_div == LAST_DIV);

    always_comb begin
        w_state_next = r_state;
        w_word_next  = r_word;
        w_nib_next   = r_nib;
        w_bit_next   = r_bit;
        w_div_next   = r_div;
        case (r_state)
            ST_IDLE: begin
                if (bus.d_valid) begin
                    w_word_next  = bus.d_in;
                    w_nib_next   = '0;
                    w_bit_next   = '0;
                    w_div_next   = '0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_div_next = w_period_end ? 16'd0 : r_div + 16'd1;
                if (w_period_end) begin
                    w_bit_next   = '0;
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                w_div_next = w_period_end ? 16'd0 : r_div + 16'd1;
                if (w_period_end) begin
                    if (r_bit == LAST_BIT) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            default: begin
                w_div_next = w_period_end ? 16'd0 : r_div + 16'd1;
                if (w_period_end) begin
                    if (r_nib == LAST_NIB) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_nib_next   = r_nib + 1'b1;
                        w_state_next = ST_START;
                    end
                end
            end
        endcase
    end

    // The encoder looks at the nibble of the next state so tx can be registered
    // without adding a cycle of latency after the handshake.
    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_nib
            if (gi < NUM_NIBBLES) begin : g_used
                assign w_nib_arr[gi] = w_word_next[4*gi +: 4];
            end else begin : g_pad
                assign w_nib_arr[gi] = 4'h0;
            end
        end
    endgenerate

    hamming_cod74 u_cod74 (
        .i_data (w_nib_arr[w_nib_next]),
        .o_cw   (w_cw)
    );

    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_cw[w_bit_next];
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_nib   <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_word  <= w_word_next;
            r_nib   <= w_nib_next;
            r_bit   <= w_bit_next;
            r_div   <= w_div_next;
            r_tx    <= w_tx_next;
        end
    end

    assign bus.tx      = r_tx;
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.d_ready = rst_n && (r_state == ST_IDLE);
    assign bus.done    = (r_state == ST_STOP) && w_period_end && (r_nib == LAST_NIB);
endmodule

// File: tb/tb_hamming_emisor_serie.sv
// Scoreboard bench for hamming_emisor_serie across three parameter sets:
// default, single-nibble SECDED, and one-clock-per-bit back-to-back.
module tb_hamming_emisor_serie;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   done_at;

    typedef struct {
        logic tx;
        logic done;
    } exp_t;

    exp_t sb_q[$];
    logic rx_q[$];

    always #5 clk = ~clk;

    hamming_emisor_serie_if #(.NUM_NIBBLES(2)) a_if ();
    hamming_emisor_serie_if #(.NUM_NIBBLES(1)) b_if ();
    hamming_emisor_serie_if #(.NUM_NIBBLES(2)) c_if ();

    hamming_emisor_serie #(.NUM_NIBBLES(2), .EXTENDED(0), .CLK_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    hamming_emisor_serie #(.NUM_NIBBLES(1), .EXTENDED(1), .CLK_DIV(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if.slave));
    hamming_emisor_serie #(.NUM_NIBBLES(2), .EXTENDED(0), .CLK_DIV(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(c_if.slave));

    function automatic logic [7:0] model_cw(input logic [3:0] d, input bit ext);
        logic [7:0] cw;
        cw    = '0;
        cw[0] = d[0] ^ d[1] ^ d[3];
        cw[1] = d[0] ^ d[2] ^ d[3];
        cw[2] = d[0];
        cw[3] = d[1] ^ d[2] ^ d[3];
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        cw[7] = ext ? ^cw[6:0] : 1'b0;
        return cw;
    endfunction

    task automatic push_frame(input logic [31:0] word, input int n, input bit ext, input int div);
        logic [7:0] cw;
        logic [3:0] nib;
        int         w;
        exp_t       e;
        w = ext ? 8 : 7;
        for (int k = 0; k < n; k++) begin
            nib = word[4*k +: 4];
            cw  = model_cw(nib, ext);
            for (int b = 0; b < w + 2; b++) begin
                for (int c = 0; c < div; c++) begin
                    e.tx   = (b == 0) ? 1'b0 : (b == w + 1) ? 1'b1 : cw[b-1];
                    e.done = (k == n - 1) && (b == w + 1) && (c == div - 1);
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    task automatic set_in(input int sel, input logic [31:0] word, input logic valid);
        case (sel)
            0:       begin a_if.d_in = word[7:0]; a_if.d_valid = valid; end
            1:       begin b_if.d_in = word[3:0]; b_if.d_valid = valid; end
            default: begin c_if.d_in = word[7:0]; c_if.d_valid = valid; end
        endcase
    endtask

    task automatic get_obs(input int sel, output logic tx, output logic dn,
                           output logic bz, output logic rd);
        case (sel)
            0:       begin tx = a_if.tx; dn = a_if.done; bz = a_if.busy; rd = a_if.d_ready; end
            1:       begin tx = b_if.tx; dn = b_if.done; bz = b_if.busy; rd = b_if.d_ready; end
            default: begin tx = c_if.tx; dn = c_if.done; bz = c_if.busy; rd = c_if.d_ready; end
        endcase
    endtask

    task automatic handshake(input int sel, input logic [31:0] word, input string tag);
        logic tx, dn, bz, rd;
        int   waited;
        @(negedge clk);
        set_in(sel, word, 1'b1);
        get_obs(sel, tx, dn, bz, rd);
        waited = 0;
        while (rd !== 1'b1 && waited < 200) begin
            @(negedge clk);
            get_obs(sel, tx, dn, bz, rd);
            waited++;
        end
        total++;
        if (rd !== 1'b1) begin
            bad++;
            $display("FAIL %s handshake: d_ready=%b after %0d cycles, required 1", tag, rd, waited);
            set_in(sel, 32'h0, 1'b0);
        end
    endtask

    // Called just before the accepting edge; checks every cycle of the frame.
    task automatic check_frame(input int sel, input logic [31:0] word, input int n, input bit ext,
                               input int div, input bit keep, input logic [31:0] next_word,
                               input string tag);
        exp_t e;
        logic tx, dn, bz, rd;
        int   cyc;
        sb_q.delete();
        rx_q.delete();
        done_at = -1;
        push_frame(word, n, ext, div);
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) set_in(sel, keep ? next_word : 32'h0, keep);
            e = sb_q.pop_front();
            get_obs(sel, tx, dn, bz, rd);
            rx_q.push_back(tx);
            if (dn === 1'b1 && done_at < 0) done_at = cyc;
            total++;
            if ({tx, dn, bz, rd} !== {e.tx, e.done, 2'b10}) begin
                bad++;
                $display("FAIL %s cycle %0d: tx/done/busy/ready=%b%b%b%b, required %b%b10",
                         tag, cyc, tx, dn, bz, rd, e.tx, e.done);
            end
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        logic tx, dn, bz, rd;
        @(negedge clk);
        get_obs(sel, tx, dn, bz, rd);
        total++;
        if ({tx, dn, bz, rd} !== 4'b1001) begin
            bad++;
            $display("FAIL %s idle: tx/done/busy/ready=%b%b%b%b, required 1001", tag, tx, dn, bz, rd);
        end
    endtask

    task automatic test_reset();
        logic tx, dn, bz, rd;
        #12;
        for (int s = 0; s < 3; s++) begin
            get_obs(s, tx, dn, bz, rd);
            total++;
            if ({tx, dn, bz, rd} !== 4'b1000) begin
                bad++;
                $display("FAIL reset dut%0d: tx/done/busy/ready=%b%b%b%b, required 1000", s, tx, dn, bz, rd);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_idle(0, "reset_release_a");
        check_idle(1, "reset_release_b");
        check_idle(2, "reset_release_c");
    endtask

    task automatic test_default();
        handshake(0, 32'h0B, "default_0B");
        check_frame(0, 32'h0B, 2, 1'b0, 4, 1'b0, 32'h0, "default_0B");
        total++;
        if (done_at !== 72) begin
            bad++;
            $display("FAIL default_0B done_cycle: got %0d, required 72", done_at);
        end
        check_idle(0, "default_0B");
        handshake(0, 32'hA5, "default_A5");
        check_frame(0, 32'hA5, 2, 1'b0, 4, 1'b0, 32'h0, "default_A5");
        check_idle(0, "default_A5");
    endtask

    task automatic test_extended_single();
        logic [7:0] rxcw;
        handshake(1, 32'h1, "ext_1");
        check_frame(1, 32'h1, 1, 1'b1, 3, 1'b0, 32'h0, "ext_1");
        for (int j = 0; j < 8; j++) rxcw[j] = rx_q[(1 + j) * 3 + 1];
        total++;
        if (rxcw !== 8'h87) begin
            bad++;
            $display("FAIL ext_1 codeword: got %h, required 87", rxcw);
        end
        check_idle(1, "ext_1");
    endtask

    task automatic test_exhaustive();
        logic [7:0] c;
        logic [2:0] syn;
        logic [3:0] data;
        for (int v = 0; v < 16; v++) begin
            handshake(1, 32'(v), "exhaustive");
            check_frame(1, 32'(v), 1, 1'b1, 3, 1'b0, 32'h0, "exhaustive");
            for (int j = 0; j < 8; j++) c[j] = rx_q[(1 + j) * 3 + 1];
            syn  = {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
            data = {c[6], c[5], c[4], c[2]};
            total++;
            if ({syn, ^c, data} !== {3'b000, 1'b0, 4'(v)}) begin
                bad++;
                $display("FAIL exhaustive nibble %h: syndrome=%b parity=%b data=%h, required 000 0 %h",
                         v, syn, ^c, data, v);
            end
        end
        check_idle(1, "exhaustive");
    endtask

    task automatic test_back_to_back();
        handshake(2, 32'h3C, "b2b_first");
        check_frame(2, 32'h3C, 2, 1'b0, 1, 1'b1, 32'h5A, "b2b_first");
        check_idle(2, "b2b_gap");
        check_frame(2, 32'h5A, 2, 1'b0, 1, 1'b0, 32'h0, "b2b_second");
        check_idle(2, "b2b_second");
    endtask

    task automatic test_reset_mid_frame();
        logic tx, dn, bz, rd;
        handshake(0, 32'hC7, "midreset");
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) set_in(0, 32'h0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        get_obs(0, tx, dn, bz, rd);
        total++;
        if ({tx, dn, bz, rd} !== 4'b1000) begin
            bad++;
            $display("FAIL midreset assert: tx/done/busy/ready=%b%b%b%b, required 1000", tx, dn, bz, rd);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            get_obs(0, tx, dn, bz, rd);
            total++;
            if (dn !== 1'b0) begin
                bad++;
                $display("FAIL midreset done: got %b, required 0", dn);
            end
        end
        rst_n = 1'b1;
        check_idle(0, "midreset_release");
        handshake(0, 32'h96, "midreset_new");
        check_frame(0, 32'h96, 2, 1'b0, 4, 1'b0, 32'h0, "midreset_new");
        check_idle(0, "midreset_new");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(0, 32'h0, 1'b0);
        set_in(1, 32'h0, 1'b0);
        set_in(2, 32'h0, 1'b0);
        test_reset();
        test_default();
        test_extended_single();
        test_exhaustive();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
